// File: rtl/reg_dump_ctrl_pkg.sv
// Shared CPU definitions: register-file geometry, register indices, dump FSM encoding.
package reg_dump_ctrl_pkg;

  // Register-file geometry, shared with the register file itself
  localparam int unsigned RF_NUM_REGS = 8;
  localparam int unsigned RF_DATA_W   = 8;
  localparam int unsigned RF_ADDR_W   = 3;

  // Register indices
  localparam int unsigned REG_A = 0;
  localparam int unsigned REG_B = 1;
  localparam int unsigned REG_C = 2;
  localparam int unsigned REG_D = 3;
  localparam int unsigned REG_E = 4;
  localparam int unsigned REG_F = 5;
  localparam int unsigned REG_G = 6;
  localparam int unsigned REG_H = 7;

  // Dump sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Valid/ready stream carrying one register value and its index per beat.
interface reg_dump_ctrl_if #(
  parameter int unsigned DATA_W = reg_dump_ctrl_pkg::RF_DATA_W,
  parameter int unsigned ADDR_W = reg_dump_ctrl_pkg::RF_ADDR_W
);

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_last;

  // Producer side (the dump sequencer)
  modport master (
    output dump_valid,
    output dump_data,
    output dump_idx,
    output dump_last,
    input  dump_ready
  );

  // Consumer side (oport, debug or UART path)
  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_idx,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/reg_dump_ctrl.sv
// Streams the register file out over a valid/ready port when the CPU halts.
// The read port belongs to this block only while busy is high.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              busy,
  output logic              done,
  reg_dump_ctrl_if.master   dump
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(REG_A);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state;
  logic              halt_q;
  logic [ADDR_W-1:0] idx;
  logic              start_c;
  logic              handshake_c;

  assign start_c     = halt & ~halt_q;
  assign handshake_c = dump.dump_valid & dump.dump_ready;

  // Halt history for rising-edge detection; cleared by reset so a held halt re-triggers
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt;
    end
  end

  // Dump sequencer: every output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= FIRST_IDX;
      rf_rd_en        <= 1'b0;
      rf_rd_addr      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_data  <= '0;
      dump.dump_idx   <= '0;
      dump.dump_last  <= 1'b0;
    end else if (!halt && state != ST_IDLE) begin
      // Halt released: abandon any dump in flight (or leave DONE) and clear everything
      state           <= ST_IDLE;
      idx             <= FIRST_IDX;
      rf_rd_en        <= 1'b0;
      rf_rd_addr      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_data  <= '0;
      dump.dump_idx   <= '0;
      dump.dump_last  <= 1'b0;
    end else begin
      rf_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            state      <= ST_READ;
            idx        <= FIRST_IDX;
            rf_rd_en   <= 1'b1;
            rf_rd_addr <= FIRST_IDX;
            busy       <= 1'b1;
          end
        end
        ST_READ: begin
          // Read data for idx arrives during the next cycle
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state           <= ST_SEND;
          dump.dump_valid <= 1'b1;
          dump.dump_data  <= rf_rd_data;
          dump.dump_idx   <= idx;
          dump.dump_last  <= (idx == LAST_IDX);
        end
        ST_SEND: begin
          if (handshake_c) begin
            dump.dump_valid <= 1'b0;
            dump.dump_last  <= 1'b0;
            if (idx >= LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= ST_READ;
              idx        <= idx + ADDR_W'(1);
              rf_rd_en   <= 1'b1;
              rf_rd_addr <= idx + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Hold until halt drops; no re-trigger while it stays high
          state <= ST_DONE;
        end
        default: begin
          state           <= ST_IDLE;
          idx             <= FIRST_IDX;
          busy            <= 1'b0;
          done            <= 1'b0;
          dump.dump_valid <= 1'b0;
          dump.dump_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: directed scenarios plus randomized dumps against a beat-level model.
module tb_reg_dump_ctrl;
  import reg_dump_ctrl_pkg::*;

  localparam int unsigned NR = RF_NUM_REGS;
  localparam int unsigned DW = RF_DATA_W;
  localparam int unsigned AW = RF_ADDR_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          halt;
  logic          rf_rd_en;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          busy;
  logic          done;

  reg_dump_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) dump_if ();

  reg_dump_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .busy       (busy),
    .done       (done),
    .dump       (dump_if)
  );

  always #5 clk = ~clk;

  // Register file model: data one cycle after the strobe, junk otherwise
  logic [DW-1:0] regs [NR];
  always @(posedge clk) begin
    rf_rd_data <= rf_rd_en ? regs[rf_rd_addr] : DW'(8'h5A);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat-level reference: a halt rising edge opens a session expecting indices 0..NR-1 in order
  int            beats      = 0;
  int            exp_next   = 0;
  int            session    = 0;
  int            halt_prev  = 0;
  int            prev_stall = 0;
  logic [DW-1:0] p_data;
  logic [AW-1:0] p_idx;

  always @(negedge clk) begin
    #2;
    if (dump_if.dump_valid) begin
      check("valid_in_session", 32'(session), 32'd1);
      check("rd_en_during_send", 32'(rf_rd_en), 32'd0);
      check("last_flag", 32'(dump_if.dump_last), 32'(dump_if.dump_idx == AW'(NR - 1)));
    end
    if (prev_stall != 0) begin
      check("stall_valid", 32'(dump_if.dump_valid), 32'd1);
      check("stall_data", 32'(dump_if.dump_data), 32'(p_data));
      check("stall_idx", 32'(dump_if.dump_idx), 32'(p_idx));
    end
    if (reset) begin
      session    = 0;
      halt_prev  = 0;
      prev_stall = 0;
    end else begin
      if (dump_if.dump_valid && dump_if.dump_ready) begin
        check("beat_idx", 32'(dump_if.dump_idx), 32'(exp_next));
        check("beat_data", 32'(dump_if.dump_data), 32'(regs[dump_if.dump_idx]));
        exp_next++;
        beats++;
      end
      prev_stall = (dump_if.dump_valid && !dump_if.dump_ready && halt) ? 1 : 0;
      p_data     = dump_if.dump_data;
      p_idx      = dump_if.dump_idx;
      if (halt && halt_prev == 0) begin
        session  = 1;
        exp_next = 0;
      end else if (!halt) begin
        session = 0;
      end
      halt_prev = halt ? 1 : 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, first_valid, first_done, last_cnt, rd_cnt, stall, idx2, found, vcnt, aborted, got_done;

    reset = 1'b1;
    halt  = 1'b0;
    dump_if.dump_ready = 1'b0;
    for (int i = 0; i < int'(NR); i++) regs[i] = DW'(17 * (i + 1));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(dump_if.dump_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rf_rd_en), 32'd0);
    check("rst_data", 32'(dump_if.dump_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Full dump with ready high, then halt held long after done
    dump_if.dump_ready = 1'b1;
    b0 = beats; first_valid = -1; first_done = -1; last_cnt = 0; rd_cnt = 0;
    halt = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (dump_if.dump_valid && first_valid < 0) first_valid = n;
      if (done && first_done < 0) first_done = n;
      if (dump_if.dump_last) last_cnt++;
      if (rf_rd_en) rd_cnt++;
    end
    check("t1_first_valid", 32'(first_valid), 32'd2);
    check("t1_done_time", 32'(first_done), 32'd24);
    check("t1_beats", 32'(beats - b0), 32'(NR));
    check("t1_last_cnt", 32'(last_cnt), 32'd1);
    check("t1_rd_cnt", 32'(rd_cnt), 32'(NR));
    check("t1_done_held", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t1_done_clear", 32'(done), 32'd0);
    check("t1_busy_clear", 32'(busy), 32'd0);
    tick();

    // Five-cycle stall on beat 2
    b0 = beats; stall = 0; idx2 = 0; first_done = -1;
    halt = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      #1;
      if (done) begin
        first_done = n;
        break;
      end
      if (dump_if.dump_valid && dump_if.dump_idx == AW'(2)) begin
        idx2++;
        dump_if.dump_ready = (stall >= 5);
        if (stall < 5) stall++;
      end else begin
        dump_if.dump_ready = 1'b1;
      end
    end
    check("t2_idx2_cycles", 32'(idx2), 32'd6);
    check("t2_done_time", 32'(first_done), 32'd29);
    check("t2_beats", 32'(beats - b0), 32'(NR));
    dump_if.dump_ready = 1'b1;
    @(posedge clk);
    #1;
    halt = 1'b0;
    tick();
    tick();

    // Abort while beat 4 is presented, then restart from index 0
    b0 = beats; found = 0;
    halt = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (dump_if.dump_valid && dump_if.dump_idx == AW'(4)) begin
        halt = 1'b0;
        found = 1;
        @(negedge clk);
        check("t3_valid_after_abort", 32'(dump_if.dump_valid), 32'd0);
        check("t3_busy_after_abort", 32'(busy), 32'd0);
        break;
      end
    end
    check("t3_found", 32'(found), 32'd1);
    check("t3_beats", 32'(beats - b0), 32'd5);
    tick();
    tick();
    b0 = beats; first_done = -1;
    halt = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 2) begin
        check("t3_restart_valid", 32'(dump_if.dump_valid), 32'd1);
        check("t3_restart_idx", 32'(dump_if.dump_idx), 32'd0);
        check("t3_restart_data", 32'(dump_if.dump_data), 32'h11);
      end
      if (done) begin
        first_done = n;
        break;
      end
    end
    check("t3_done_time", 32'(first_done), 32'd24);
    check("t3_restart_beats", 32'(beats - b0), 32'(NR));
    @(posedge clk);
    #1;
    halt = 1'b0;
    tick();
    tick();

    // Reset during beat 5 with halt held high
    found = 0;
    halt = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (dump_if.dump_valid && dump_if.dump_idx == AW'(5)) begin
        reset = 1'b1;
        found = 1;
        break;
      end
    end
    check("t4_found", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_valid", 32'(dump_if.dump_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_rd_en", 32'(rf_rd_en), 32'd0);
    check("t4_rd_addr", 32'(rf_rd_addr), 32'd0);
    check("t4_data", 32'(dump_if.dump_data), 32'd0);
    check("t4_idx", 32'(dump_if.dump_idx), 32'd0);
    check("t4_last", 32'(dump_if.dump_last), 32'd0);
    b0 = beats; first_valid = -1; first_done = -1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dump_if.dump_valid && first_valid < 0) first_valid = n;
      if (done) begin
        first_done = n;
        break;
      end
    end
    check("t4_first_valid", 32'(first_valid), 32'd2);
    check("t4_done_time", 32'(first_done), 32'd24);
    check("t4_beats", 32'(beats - b0), 32'(NR));
    @(posedge clk);
    #1;
    halt = 1'b0;
    tick();
    tick();

    // One-cycle halt pulse: READ entered then abandoned, no beat
    b0 = beats; vcnt = 0;
    halt = 1'b1;
    @(posedge clk);
    #1;
    halt = 1'b0;
    @(negedge clk);
    check("t6_busy_read", 32'(busy), 32'd1);
    check("t6_rd_en_read", 32'(rf_rd_en), 32'd1);
    check("t6_rd_addr_read", 32'(rf_rd_addr), 32'd0);
    @(negedge clk);
    check("t6_busy_abort", 32'(busy), 32'd0);
    check("t6_rd_en_abort", 32'(rf_rd_en), 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (dump_if.dump_valid) vcnt++;
    end
    check("t6_no_valid", 32'(vcnt), 32'd0);
    check("t6_no_beats", 32'(beats - b0), 32'd0);
    tick();

    // Randomized register contents, back-pressure and occasional aborts
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < int'(NR); i++) regs[i] = DW'($urandom_range(0, 255));
      b0 = beats; aborted = 0; got_done = 0;
      halt = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tick();
        dump_if.dump_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 63) == 0) begin
          halt = 1'b0;
          aborted = 1;
          break;
        end
        if (done) begin
          got_done = 1;
          break;
        end
      end
      if (aborted == 0) begin
        check("rnd_done", 32'(got_done), 32'd1);
        check("rnd_beats", 32'(beats - b0), 32'(NR));
      end
      halt = 1'b0;
      tick();
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
